// File: rtl/fpu_addsub_arbiter.sv
// rtl/fpu_addsub_arbiter.sv - round-robin sharing of one add/sub datapath between two requesters

// First-word fall-through response queue; head reads as zero when empty.
module fpu_addsub_rsp_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             valid,
  output logic [WIDTH-1:0] rd_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;

  assign valid   = (count != '0);
  assign pop     = rd_en && valid;
  assign rd_data = valid ? mem[rd_ptr] : '0;

  // Storage array; the credit scheme upstream guarantees a free slot on every write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous write and pop leaves count unchanged.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (pop)   rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end
endmodule

// Arbiter, issue register, tag pipeline and response steering.
module fpu_addsub_arbiter #(
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 3,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic [2:0]       rsp0_flag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [2:0]       rsp1_flag,
  output logic             dp_valid,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_op,
  input  logic             dp_res_valid,
  input  logic [WIDTH-1:0] dp_res,
  input  logic [2:0]       dp_flag,
  output logic             busy,
  output logic             err_unexpected_res
);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(OUT_DEPTH);

  logic [CW-1:0]      credit [2];
  logic [1:0]         req_valid;
  logic [1:0]         pop;
  logic [1:0]         elig;
  logic [1:0]         grant;
  logic               rr;
  logic               dp_id;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_id;
  logic               fin_v;
  logic               fin_id;
  logic               wr0;
  logic               wr1;
  logic [WIDTH+2:0]   f0_head;
  logic [WIDTH+2:0]   f1_head;

  assign req_valid = {req1_valid, req0_valid};
  assign pop       = {rsp1_valid && rsp1_ready, rsp0_valid && rsp0_ready};

  // Eligibility uses the post-pop credit so a pop frees a slot for acceptance in the same cycle.
  always_comb begin
    elig = '0;
    for (int n = 0; n < 2; n++) begin
      elig[n] = req_valid[n] && ((credit[n] - CW'(pop[n])) < CREDIT_MAX);
    end
  end

  // Round-robin grant: contention goes to rr, otherwise the lone eligible requester wins.
  always_comb begin
    grant = '0;
    if (!arst) begin
      if (elig[0] && elig[1]) grant[rr] = 1'b1;
      else                    grant = elig;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Issue register toward the datapath and round-robin pointer update.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rr       <= 1'b0;
      dp_valid <= 1'b0;
      dp_a     <= '0;
      dp_b     <= '0;
      dp_op    <= 1'b0;
      dp_id    <= 1'b0;
    end else begin
      dp_valid <= |grant;
      if (|grant) begin
        rr    <= ~grant[1];
        dp_id <= grant[1];
        dp_a  <= grant[1] ? req1_a  : req0_a;
        dp_b  <= grant[1] ? req1_b  : req0_b;
        dp_op <= grant[1] ? req1_op : req0_op;
      end
    end
  end

  // Credits count in-flight ops plus queued responses per requester.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int n = 0; n < 2; n++) credit[n] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) credit[n] <= credit[n] + CW'(grant[n]) - CW'(pop[n]);
    end
  end

  // Tag pipeline tracks which requester owns the result arriving LATENCY cycles after issue.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= dp_valid;
      tag_id[0] <= dp_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign fin_v  = tag_v[LATENCY-1];
  assign fin_id = tag_id[LATENCY-1];
  assign wr0    = fin_v && dp_res_valid && !fin_id;
  assign wr1    = fin_v && dp_res_valid &&  fin_id;

  // Sticky error when a result and its expected tag disagree; such a result is dropped.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                        err_unexpected_res <= 1'b0;
    else if (fin_v ^ dp_res_valid)   err_unexpected_res <= 1'b1;
  end

  fpu_addsub_rsp_fifo #(.WIDTH(WIDTH + 3), .DEPTH(OUT_DEPTH)) u_fifo0 (
    .clk     (clk),
    .arst    (arst),
    .wr_en   (wr0),
    .wr_data ({dp_flag, dp_res}),
    .rd_en   (rsp0_ready),
    .valid   (rsp0_valid),
    .rd_data (f0_head)
  );

  fpu_addsub_rsp_fifo #(.WIDTH(WIDTH + 3), .DEPTH(OUT_DEPTH)) u_fifo1 (
    .clk     (clk),
    .arst    (arst),
    .wr_en   (wr1),
    .wr_data ({dp_flag, dp_res}),
    .rd_en   (rsp1_ready),
    .valid   (rsp1_valid),
    .rd_data (f1_head)
  );

  assign rsp0_data = f0_head[WIDTH-1:0];
  assign rsp0_flag = f0_head[WIDTH+2:WIDTH];
  assign rsp1_data = f1_head[WIDTH-1:0];
  assign rsp1_flag = f1_head[WIDTH+2:WIDTH];

  assign busy = (credit[0] != '0) || (credit[1] != '0) || dp_valid;
endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb/tb_fpu_addsub_arbiter.sv - directed self-checking bench for fpu_addsub_arbiter
module tb_fpu_addsub_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        arst;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [2:0]  rsp0_flag, rsp1_flag;
  logic        dp_valid, dp_op, dp_res_valid;
  logic [31:0] dp_a, dp_b, dp_res;
  logic [2:0]  dp_flag;
  logic        busy, err;
  logic        inj, drop;

  int n_cmp = 0;
  int n_bad = 0;

  logic [34:0] q0[$];
  logic [34:0] q1[$];
  int          ord_q[$];

  always #5 clk = ~clk;

  fpu_addsub_arbiter #(.WIDTH(32), .LATENCY(LAT), .OUT_DEPTH(4)) dut (
    .clk(clk), .arst(arst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_flag(rsp0_flag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_flag(rsp1_flag),
    .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
    .dp_res_valid(dp_res_valid), .dp_res(dp_res), .dp_flag(dp_flag),
    .busy(busy), .err_unexpected_res(err)
  );

  // Datapath stand-in: two known IEEE cases, otherwise an arbitrary but deterministic mix.
  function automatic logic [34:0] dp_fn(logic [31:0] a, logic [31:0] b, logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && !op) return {3'b000, 32'h40400000};
    if (a == 32'h7F800000 && b == 32'h7F800000 &&  op) return {3'b001, 32'h7FC00000};
    return {a[2:0] ^ b[2:0] ^ {2'b00, op}, a ^ {b[15:0], b[31:16]}};
  endfunction

  function automatic logic [31:0] a0f(int k); return 32'h3000_0000 + 32'(k * 16); endfunction
  function automatic logic [31:0] b0f(int k); return 32'h0100_0003 + 32'(k);      endfunction
  function automatic logic [31:0] a1f(int k); return 32'h5000_0005 + 32'(k * 32); endfunction
  function automatic logic [31:0] b1f(int k); return 32'h0002_0001 + 32'(k * 3);  endfunction

  logic [LAT-1:0] dm_v;
  logic [34:0]    dm_r [LAT];

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      dm_v <= '0;
      for (int i = 0; i < LAT; i++) dm_r[i] <= '0;
    end else begin
      dm_v[0] <= dp_valid;
      dm_r[0] <= dp_fn(dp_a, dp_b, dp_op);
      for (int i = 1; i < LAT; i++) begin
        dm_v[i] <= dm_v[i-1];
        dm_r[i] <= dm_r[i-1];
      end
    end
  end

  assign dp_res_valid = (dm_v[LAT-1] & ~drop) | inj;
  assign dp_res       = dm_r[LAT-1][31:0];
  assign dp_flag      = dm_r[LAT-1][34:32];

  // Response collector, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rsp0_valid && rsp0_ready) begin q0.push_back({rsp0_flag, rsp0_data}); ord_q.push_back(0); end
    if (rsp1_valid && rsp1_ready) begin q1.push_back({rsp1_flag, rsp1_data}); ord_q.push_back(1); end
  end

  task automatic idle_inputs();
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0; inj = 0; drop = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    arst = 1; idle_inputs();
    @(posedge clk); #1;
    arst = 0;
    q0.delete(); q1.delete(); ord_q.delete();
  endtask

  task automatic test_reset();
    arst = 1; idle_inputs();
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    n_cmp++; if ({dp_valid, rsp0_valid, rsp1_valid, busy, err, dp_a, rsp0_data, rsp1_flag} !== '0) begin
      n_bad++; $display("FAIL reset_outputs dp_valid=%b rsp_valid=%b%b busy=%b err=%b dp_a=%h rsp0_data=%h exp all 0",
                        dp_valid, rsp0_valid, rsp1_valid, busy, err, dp_a, rsp0_data); end
    @(posedge clk); #1;
    idle_inputs(); arst = 0;
  endtask

  task automatic test_single_add();
    do_reset();
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = 0;
    @(negedge clk);
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_bad++; $display("FAIL add_grant got=%b exp=01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    n_cmp++; if ({dp_valid, dp_a, dp_b, dp_op} !== {1'b1, 32'h3F800000, 32'h40000000, 1'b0}) begin
      n_bad++; $display("FAIL add_issue got v=%b a=%h b=%h op=%b exp 1 3f800000 40000000 0", dp_valid, dp_a, dp_b, dp_op); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (rsp0_valid !== (k == 4)) begin n_bad++; $display("FAIL add_latency_e%0d rsp0_valid=%b exp=%b", k, rsp0_valid, k == 4); end
    end
    n_cmp++; if ({rsp0_data, rsp0_flag, rsp1_valid} !== {32'h40400000, 3'b000, 1'b0}) begin
      n_bad++; $display("FAIL add_result data=%h flag=%b rsp1_valid=%b exp 40400000 000 0", rsp0_data, rsp0_flag, rsp1_valid); end
    @(posedge clk); #1; rsp0_ready = 1;
    @(posedge clk); #1; rsp0_ready = 0;
    @(negedge clk);
    n_cmp++; if ({rsp0_valid, rsp0_data, busy} !== '0) begin
      n_bad++; $display("FAIL add_popped rsp0_valid=%b data=%h busy=%b exp 0 0 0", rsp0_valid, rsp0_data, busy); end
  endtask

  task automatic test_contention();
    int i0 = 0;
    int i1 = 0;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    for (int c = 0; c < 8; c++) begin
      req0_valid = 1; req0_a = a0f(i0); req0_b = b0f(i0); req0_op = i0[0];
      req1_valid = 1; req1_a = a1f(i1); req1_b = b1f(i1); req1_op = ~i1[0];
      @(negedge clk);
      n_cmp++; if ({req1_ready, req0_ready} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL contend_grant_c%0d got=%b exp=%b", c, {req1_ready, req0_ready}, (c % 2 == 0) ? 2'b01 : 2'b10); end
      if (c > 0) begin
        n_cmp++; if (dp_valid !== 1'b1) begin n_bad++; $display("FAIL contend_dp_valid_c%0d got=%b exp=1", c, dp_valid); end
      end
      i0 += int'(req0_ready); i1 += int'(req1_ready);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    repeat (10) @(posedge clk); #1;
    n_cmp++; if (q0.size() != 4 || q1.size() != 4 || ord_q.size() != 8) begin
      n_bad++; $display("FAIL contend_count q0=%0d q1=%0d total=%0d exp 4 4 8", q0.size(), q1.size(), ord_q.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (q0[k] !== dp_fn(a0f(k), b0f(k), k[0])) begin n_bad++; $display("FAIL contend_rsp0_%0d got=%h exp=%h", k, q0[k], dp_fn(a0f(k), b0f(k), k[0])); end
        n_cmp++; if (q1[k] !== dp_fn(a1f(k), b1f(k), ~k[0])) begin n_bad++; $display("FAIL contend_rsp1_%0d got=%h exp=%h", k, q1[k], dp_fn(a1f(k), b1f(k), ~k[0])); end
      end
      for (int k = 0; k < 8; k++) begin
        n_cmp++; if (ord_q[k] != k % 2) begin n_bad++; $display("FAIL contend_order_%0d got=%0d exp=%0d", k, ord_q[k], k % 2); end
      end
    end
  endtask

  task automatic test_credit();
    int i0 = 0;
    int i1 = 0;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 0;
    for (int c = 0; c < 14; c++) begin
      req0_valid = 1; req0_a = a0f(i0); req0_b = b0f(i0); req0_op = i0[0];
      req1_valid = 1; req1_a = a1f(i1); req1_b = b1f(i1); req1_op = ~i1[0];
      @(negedge clk);
      if (c >= 8) begin
        n_cmp++; if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL credit_block_c%0d req1_ready=%b exp=0", c, req1_ready); end
      end
      i0 += int'(req0_ready); i1 += int'(req1_ready);
      @(posedge clk); #1;
    end
    n_cmp++; if (i1 != 4 || i0 != 9) begin n_bad++; $display("FAIL credit_handshakes req1=%0d req0=%0d exp 4 9", i1, i0); end
    req0_valid = 0; rsp1_ready = 1;
    req1_a = a1f(i1); req1_b = b1f(i1); req1_op = ~i1[0];
    @(negedge clk);
    n_cmp++; if ({rsp1_valid, req1_ready} !== 2'b11) begin n_bad++; $display("FAIL credit_pop_reopen rsp1_valid=%b req1_ready=%b exp 1 1", rsp1_valid, req1_ready); end
    i1 += int'(req1_ready);
    @(posedge clk); #1;
    rsp1_ready = 0; req1_a = a1f(i1); req1_b = b1f(i1); req1_op = ~i1[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      i1 += int'(req1_ready);
      @(posedge clk); #1;
    end
    n_cmp++; if (i1 != 5) begin n_bad++; $display("FAIL credit_one_more req1 handshakes=%0d exp=5", i1); end
    req1_valid = 0; rsp1_ready = 1;
    repeat (14) @(posedge clk); #1;
    n_cmp++; if (q1.size() != 5 || q0.size() != 9) begin n_bad++; $display("FAIL credit_no_overflow q1=%0d q0=%0d exp 5 9", q1.size(), q0.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++; if (q1[k] !== dp_fn(a1f(k), b1f(k), ~k[0])) begin n_bad++; $display("FAIL credit_rsp1_%0d got=%h exp=%h", k, q1[k], dp_fn(a1f(k), b1f(k), ~k[0])); end
      end
    end
  endtask

  task automatic test_flag();
    do_reset();
    req1_valid = 1; req1_a = 32'h7F800000; req1_b = 32'h7F800000; req1_op = 1;
    @(negedge clk);
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_bad++; $display("FAIL flag_grant got=%b exp=10", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    req1_valid = 0;
    repeat (5) @(negedge clk);
    n_cmp++; if ({rsp1_valid, rsp1_data, rsp1_flag, rsp0_valid} !== {1'b1, 32'h7FC00000, 3'b001, 1'b0}) begin
      n_bad++; $display("FAIL flag_result v=%b data=%h flag=%b rsp0_valid=%b exp 1 7fc00000 001 0", rsp1_valid, rsp1_data, rsp1_flag, rsp0_valid); end
  endtask

  task automatic test_tag_error();
    do_reset();
    inj = 1;
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tagerr_before got=%b exp=0", err); end
    @(posedge clk); #1;
    inj = 0;
    @(negedge clk);
    n_cmp++; if ({err, rsp0_valid, rsp1_valid} !== 3'b100) begin n_bad++; $display("FAIL tagerr_set err=%b rsp_valid=%b%b exp 1 0 0", err, rsp0_valid, rsp1_valid); end
    repeat (5) @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tagerr_sticky got=%b exp=1", err); end
    do_reset();
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tagerr_cleared got=%b exp=0", err); end
    @(posedge clk); #1;
    drop = 1; req0_valid = 1; req0_a = a0f(3); req0_b = b0f(3); req0_op = 0;
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (6) @(negedge clk);
    n_cmp++; if ({err, rsp0_valid} !== 2'b10) begin n_bad++; $display("FAIL tagerr_missing_result err=%b rsp0_valid=%b exp 1 0", err, rsp0_valid); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req0_valid = 1; req0_a = a0f(1); req0_b = b0f(1); req0_op = 0;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 1; req1_a = a1f(1); req1_b = b1f(1); req1_op = 1;
    @(posedge clk); #1;
    req1_valid = 0; req0_valid = 1; req0_a = a0f(2);
    @(posedge clk); #1;
    arst = 1; req0_valid = 0;
    @(negedge clk);
    n_cmp++; if ({req0_ready, req1_ready, dp_valid, dp_a, dp_b, dp_op, rsp0_valid, rsp1_valid, busy, err} !== '0) begin
      n_bad++; $display("FAIL midreset_outputs dp_valid=%b dp_a=%h rsp_valid=%b%b busy=%b err=%b exp all 0", dp_valid, dp_a, rsp0_valid, rsp1_valid, busy, err); end
    @(posedge clk); #1;
    arst = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++; if ({rsp0_valid, rsp1_valid, err, busy} !== 4'b0000) begin
        n_bad++; $display("FAIL midreset_quiet_c%0d rsp_valid=%b%b err=%b busy=%b exp 0", c, rsp0_valid, rsp1_valid, err, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_credit();
    test_flag();
    test_tag_error();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
